apb_cmd_master: RTL



---
 rtl/apb_cmd_master.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/apb_cmd_master.sv
// APB requester: takes one command at a time on a valid/ready port, runs a
// SETUP/ACCESS transfer with a wait-state timeout, and returns the result.
module apb_cmd_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic                r_psel, w_psel_nx;
  logic                r_penable, w_penable_nx;
  logic                r_pwrite, w_pwrite_nx;
  logic [ADDR_W-1:0]   r_paddr, w_paddr_nx;
  logic [DATA_W-1:0]   r_pwdata, w_pwdata_nx;
  logic                r_rsp_valid, w_rsp_valid_nx;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nx;
  logic                r_rsp_err, w_rsp_err_nx;
  logic                r_rsp_timeout, w_rsp_timeout_nx;
  logic                w_timeout_hit;

  // The edge that sees pready low for the TIMEOUT-th time is the abort edge.
  assign w_timeout_hit = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  assign cmd_ready = (r_state == S_IDLE) && !preset;

  always_comb begin
    // NOTE: every target gets a hold default before the case, so no path can infer a latch.
    w_state_nx       = r_state;
    w_cnt_nx         = r_cnt;
    w_psel_nx        = r_psel;
    w_penable_nx     = r_penable;
    w_pwrite_nx      = r_pwrite;
    w_paddr_nx       = r_paddr;
    w_pwdata_nx      = r_pwdata;
    w_rsp_valid_nx   = r_rsp_valid;
    w_rsp_rdata_nx   = r_rsp_rdata;
    w_rsp_err_nx     = r_rsp_err;
    w_rsp_timeout_nx = r_rsp_timeout;

    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_state_nx   = S_SETUP;
          w_cnt_nx     = '0;
          w_psel_nx    = 1'b1;
          w_penable_nx = 1'b0;
          w_pwrite_nx  = cmd_write;
          w_paddr_nx   = cmd_addr;
          w_pwdata_nx  = cmd_wdata;
        end
      end
      S_SETUP: begin
        w_state_nx   = S_ACCESS;
        w_penable_nx = 1'b1;
      end
      S_ACCESS: begin
        if (pready) begin
          w_state_nx       = S_RESP;
          w_psel_nx        = 1'b0;
          w_penable_nx     = 1'b0;
          w_rsp_valid_nx   = 1'b1;
          w_rsp_rdata_nx   = r_pwrite ? '0 : prdata;
          w_rsp_err_nx     = pslverr;
          w_rsp_timeout_nx = 1'b0;
        end else if (w_timeout_hit) begin
          w_state_nx       = S_RESP;
          w_psel_nx        = 1'b0;
          w_penable_nx     = 1'b0;
          w_rsp_valid_nx   = 1'b1;
          w_rsp_rdata_nx   = '0;
          w_rsp_err_nx     = 1'b1;
          w_rsp_timeout_nx = 1'b1;
        end else if (r_cnt != '1) begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nx     = S_IDLE;
          w_rsp_valid_nx = 1'b0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_psel        <= w_psel_nx;
      r_penable     <= w_penable_nx;
      r_pwrite      <= w_pwrite_nx;
      r_paddr       <= w_paddr_nx;
      r_pwdata      <= w_pwdata_nx;
      r_rsp_valid   <= w_rsp_valid_nx;
      r_rsp_rdata   <= w_rsp_rdata_nx;
      r_rsp_err     <= w_rsp_err_nx;
      r_rsp_timeout <= w_rsp_timeout_nx;
    end
  end

  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule
